ascon_round_sequencer: RTL and testbench
========================================

// Module: ascon_round_sequencer
// PURPOSE
//   Parametrised round sequencer for the ASCON permutation datapath; successor of the fixed single-round counter.
//   - Runs p^a or p^b round sequences with UNROLL rounds per cycle, under a start/done handshake.
//   - Supports datapath stall and abort.
//   - Sits between the ASCON control FSM and the permutation core.
// PARAMETERS
//   ROUND_WIDTH  4   width of round index; must be >= $clog2(MAX_ROUNDS+1)
//   MAX_ROUNDS   12  rounds in full permutation; index space 0..MAX_ROUNDS-1
//   ROUNDS_A     12  rounds for mode A (init/final)
//   ROUNDS_B     8   rounds for mode B (data/AD)
//   UNROLL       1   rounds executed per cycle; must divide ROUNDS_A and ROUNDS_B (elaboration assert)
// PORTS
//   clk           in   1                  clock, rising edge
//   rst_n         in   1                  asynchronous reset, active low
//   start_i       in   1                  request new sequence; accepted when start_i & ready_o
//   mode_i        in   1                  sampled with start: 0 = ROUNDS_A, 1 = ROUNDS_B
//   stall_i       in   1                  hold current round (datapath not ready)
//   abort_i       in   1                  terminate sequence, no done
//   ready_o       out  1                  able to accept start (state != RUN)
//   busy_o        out  1                  state == RUN
//   round_o       out  ROUND_WIDTH        first round index handled this cycle; 0 outside RUN
//   round_last_o  out  1                  RUN & round_q == MAX_ROUNDS-UNROLL
//   done_o        out  1                  one-cycle pulse after last round step
//   rc_o          out  8*UNROLL           round constants (only with ASCON_ROUND_CONST_EN)
// BEHAVIOUR
//   - Reset (async, rst_n low): state IDLE, round_q 0.
//     Output reset values: ready_o 1, busy_o 0, round_o 0, round_last_o 0, done_o 0, rc_o 0.
//   - FSM states: IDLE, RUN, DONE.
//     - IDLE/DONE + start_i & !abort_i -> RUN next cycle, round_q = MAX_ROUNDS - (mode_i ? ROUNDS_B : ROUNDS_A).
//     - DONE lasts exactly 1 cycle (done_o=1, ready_o=1), then -> IDLE unless a start is accepted.
//       Back-to-back start in DONE is legal.
//     - RUN, priority abort > stall > advance:
//       - abort_i: -> IDLE, round_q=0, no done_o.
//       - stall_i: hold everything.
//       - else if round_last_o: -> DONE, round_q=0.
//       - else round_q += UNROLL.
//   - start_i ignored in RUN. start_i & abort_i in IDLE/DONE: abort wins, start dropped.
//   - Latency: start accepted at edge N; first round visible cycle N+1.
//     done_o asserted at N+1+(rounds/UNROLL)+stall cycles.
//   - Arithmetic: round_q + UNROLL in ROUND_WIDTH bits; never exceeds MAX_ROUNDS-UNROLL in RUN.
//     Assertion: round_q <= MAX_ROUNDS-UNROLL whenever busy_o.
//   - mode_i, stall_i and abort_i outside their relevant states have no effect.
// CONFIGURATION
//   - Macro ASCON_ROUND_CONST_EN defined: port rc_o present.
//     - Lane k (bits 8k+7:8k) = {4'hF - r, r[3:0]}, where r = round_q + k.
//     - rc_o is 0 outside RUN; combinational from round_q.
//   - Undefined: rc_o port and logic absent; constants generated in the permutation core.
// STRUCTURE
//   - ascon_pack holds:
//     - MAX_ROUND_NO, ROUND_A, ROUND_B, ROUND_WIDTH (defaults for the parameters).
//     - typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DONE} ascon_seq_state_e.
//     - function ascon_rc(round) returning the 8-bit constant.
//   - One sub-module: ascon_rc_gen (combinational, UNROLL lanes), instantiated only under ASCON_ROUND_CONST_EN.
// TESTING
//   1. UNROLL=1, mode A start -> round_o 0..11 over 12 cycles; round_last_o only at 11; done_o pulse next cycle; ready_o 1.
//   2. UNROLL=2, mode B start -> round_o 4,6,8,10; round_last_o at 10; done_o 5 cycles after start edge.
//   3. UNROLL=1, mode A, stall_i high 3 cycles at round 5 -> round_o holds 5; done_o 3 cycles later than test 1.
//   4. abort_i at round 7 -> next cycle IDLE, round_o 0, no done_o.
//      start_i+abort_i together in IDLE -> stays IDLE.
//   5. rst_n low mid-RUN at round 3 -> immediately busy_o 0, round_o 0, ready_o 1.
//      Start after release runs a full sequence.
//   6. ASCON_ROUND_CONST_EN, UNROLL=2: round 0 -> rc_o 16'hE1F0; mode B round 4 -> rc_o 16'hA5B4.
//      Start in DONE cycle -> immediate new RUN.

Source files
------------

// File: rtl/ascon_round_sequencer_pkg.sv
// ============================================================================
// ascon_pack : shared defaults, sequencer state type and round-constant helper
// Rev 1.0
// ============================================================================
`default_nettype none

package ascon_pack;

    localparam int MAX_ROUND_NO = 12;
    localparam int ROUND_A      = 12;
    localparam int ROUND_B      = 8;
    localparam int ROUND_WIDTH  = 4;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } ascon_seq_state_e;

    // Upper nibble counts down while the lower nibble carries the round index
    function automatic logic [7:0] ascon_rc(input logic [3:0] round);
        return {4'hF - round, round};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_round_sequencer_if.sv
// ============================================================================
// ascon_round_sequencer_if : control-FSM <-> round sequencer handshake bundle
// Optional rc_o lanes with ASCON_ROUND_CONST_EN.  Rev 1.0
// ============================================================================
`default_nettype none

interface ascon_round_sequencer_if #(
    parameter int ROUND_WIDTH = 4
`ifdef ASCON_ROUND_CONST_EN
    ,
    parameter int UNROLL      = 1
`endif
);

    logic                   start_i;
    logic                   mode_i;
    logic                   stall_i;
    logic                   abort_i;
    logic                   ready_o;
    logic                   busy_o;
    logic [ROUND_WIDTH-1:0] round_o;
    logic                   round_last_o;
    logic                   done_o;
`ifdef ASCON_ROUND_CONST_EN
    logic [8*UNROLL-1:0]    rc_o;
`endif

    modport master (
        output start_i,
        output mode_i,
        output stall_i,
        output abort_i,
        input  ready_o,
        input  busy_o,
        input  round_o,
        input  round_last_o,
`ifdef ASCON_ROUND_CONST_EN
        input  rc_o,
`endif
        input  done_o
    );

    modport slave (
        input  start_i,
        input  mode_i,
        input  stall_i,
        input  abort_i,
        output ready_o,
        output busy_o,
        output round_o,
        output round_last_o,
`ifdef ASCON_ROUND_CONST_EN
        output rc_o,
`endif
        output done_o
    );

endinterface

`default_nettype wire

// File: rtl/ascon_round_sequencer_rc_gen.sv
// ============================================================================
// ascon_rc_gen : combinational round constants, one 8-bit lane per unrolled round
// Rev 1.0
// ============================================================================
`default_nettype none

module ascon_rc_gen
    import ascon_pack::*;
#(
    parameter int ROUND_WIDTH = ascon_pack::ROUND_WIDTH,
    parameter int UNROLL      = 1
) (
    input  wire logic [ROUND_WIDTH-1:0] round_i,
    input  wire logic                   active_i,
    output logic      [8*UNROLL-1:0]    rc_o
);

    for (genvar k = 0; k < UNROLL; k++) begin : g_lane
        logic [ROUND_WIDTH-1:0] r;
        assign r = round_i + ROUND_WIDTH'(k);
        assign rc_o[8*k +: 8] = active_i ? ascon_rc(4'(r)) : 8'h00;
    end

endmodule

`default_nettype wire

// File: rtl/ascon_round_sequencer.sv
// ============================================================================
// ascon_round_sequencer : p^a / p^b round sequencer, UNROLL rounds per cycle,
// with stall/abort.  Optional rc_o lanes via ASCON_ROUND_CONST_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module ascon_round_sequencer
    import ascon_pack::*;
#(
    parameter int ROUND_WIDTH = ascon_pack::ROUND_WIDTH,
    parameter int MAX_ROUNDS  = MAX_ROUND_NO,
    parameter int ROUNDS_A    = ROUND_A,
    parameter int ROUNDS_B    = ROUND_B,
    parameter int UNROLL      = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    ascon_round_sequencer_if.slave bus
);

    localparam logic [ROUND_WIDTH-1:0] c_last_round = ROUND_WIDTH'(MAX_ROUNDS - UNROLL);
    localparam logic [ROUND_WIDTH-1:0] c_start_a    = ROUND_WIDTH'(MAX_ROUNDS - ROUNDS_A);
    localparam logic [ROUND_WIDTH-1:0] c_start_b    = ROUND_WIDTH'(MAX_ROUNDS - ROUNDS_B);
    localparam logic [ROUND_WIDTH-1:0] c_step       = ROUND_WIDTH'(UNROLL);

    if ((UNROLL < 1) || ((ROUNDS_A % UNROLL) != 0) || ((ROUNDS_B % UNROLL) != 0)) begin : g_bad_unroll
        $error("ascon_round_sequencer: UNROLL must divide ROUNDS_A and ROUNDS_B");
    end

    if ((1 << ROUND_WIDTH) < (MAX_ROUNDS + 1)) begin : g_bad_width
        $error("ascon_round_sequencer: ROUND_WIDTH too narrow for MAX_ROUNDS");
    end

    ascon_seq_state_e       state_q, state_d;
    logic [ROUND_WIDTH-1:0] round_q, round_d;
    logic                   run;
    logic                   last;
    logic                   start_ok;

    assign run      = (state_q == SEQ_RUN);
    assign last     = run && (round_q == c_last_round);
    assign start_ok = bus.start_i && !bus.abort_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        unique case (state_q)
            SEQ_RUN: begin
                // abort beats stall, stall beats advance
                if (bus.abort_i) begin
                    state_d = SEQ_IDLE;
                    round_d = '0;
                end else if (bus.stall_i) begin
                    state_d = SEQ_RUN;
                end else if (last) begin
                    state_d = SEQ_DONE;
                    round_d = '0;
                end else begin
                    round_d = round_q + c_step;
                end
            end
            SEQ_IDLE, SEQ_DONE: begin
                if (start_ok) begin
                    state_d = SEQ_RUN;
                    round_d = bus.mode_i ? c_start_b : c_start_a;
                end else begin
                    state_d = SEQ_IDLE;
                    round_d = '0;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
                round_d = '0;
            end
        endcase
    end

    assign bus.ready_o      = !run;
    assign bus.busy_o       = run;
    assign bus.round_o      = run ? round_q : '0;
    assign bus.round_last_o = last;
    assign bus.done_o       = (state_q == SEQ_DONE);

`ifdef ASCON_ROUND_CONST_EN
    ascon_rc_gen #(
        .ROUND_WIDTH (ROUND_WIDTH),
        .UNROLL      (UNROLL)
    ) u_rc_gen (
        .round_i  (round_q),
        .active_i (run),
        .rc_o     (bus.rc_o)
    );
`endif

    a_round_range: assert property (@(posedge clk) disable iff (!rst_n)
        run |-> (round_q <= c_last_round))
        else $error("ascon_round_sequencer: round index out of range");

endmodule

`default_nettype wire

// File: tb/tb_ascon_round_sequencer.sv
// Bench for ascon_round_sequencer: directed scenarios plus randomized sequences
// on an UNROLL=1 and an UNROLL=2 instance, checked against a round-list model.
`default_nettype none

module tb_ascon_round_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic       start [2];
    logic       mode  [2];
    logic       stall [2];
    logic       abort [2];
    logic       ready [2];
    logic       busy  [2];
    logic [3:0] round [2];
    logic       last  [2];
    logic       done  [2];
`ifdef ASCON_ROUND_CONST_EN
    logic [15:0] rc   [2];
`endif

    ascon_round_sequencer_if #(.ROUND_WIDTH(4)
`ifdef ASCON_ROUND_CONST_EN
        , .UNROLL(1)
`endif
    ) if0 ();
    ascon_round_sequencer_if #(.ROUND_WIDTH(4)
`ifdef ASCON_ROUND_CONST_EN
        , .UNROLL(2)
`endif
    ) if1 ();

    ascon_round_sequencer #(.ROUND_WIDTH(4), .MAX_ROUNDS(12), .ROUNDS_A(12), .ROUNDS_B(8), .UNROLL(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    ascon_round_sequencer #(.ROUND_WIDTH(4), .MAX_ROUNDS(12), .ROUNDS_A(12), .ROUNDS_B(8), .UNROLL(2))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    assign if0.start_i = start[0];
    assign if0.mode_i  = mode[0];
    assign if0.stall_i = stall[0];
    assign if0.abort_i = abort[0];
    assign if1.start_i = start[1];
    assign if1.mode_i  = mode[1];
    assign if1.stall_i = stall[1];
    assign if1.abort_i = abort[1];

    assign ready[0] = if0.ready_o;
    assign busy[0]  = if0.busy_o;
    assign round[0] = if0.round_o;
    assign last[0]  = if0.round_last_o;
    assign done[0]  = if0.done_o;
    assign ready[1] = if1.ready_o;
    assign busy[1]  = if1.busy_o;
    assign round[1] = if1.round_o;
    assign last[1]  = if1.round_last_o;
    assign done[1]  = if1.done_o;
`ifdef ASCON_ROUND_CONST_EN
    assign rc[0] = {8'h00, if0.rc_o};
    assign rc[1] = if1.rc_o;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, "_busy"},  32'(busy[d]),  32'd0);
        chk({tag, "_ready"}, 32'(ready[d]), 32'd1);
        chk({tag, "_round"}, 32'(round[d]), 32'd0);
        chk({tag, "_last"},  32'(last[d]),  32'd0);
`ifdef ASCON_ROUND_CONST_EN
        chk({tag, "_rc"},    32'(rc[d]),    32'd0);
`endif
    endtask

    // Called at a negedge with the DUT idle (or in its DONE cycle)
    task automatic kick(input int d, input int m);
        chk("ready_before_start", 32'(ready[d]), 32'd1);
        start[d] = 1'b1;
        mode[d]  = m[0];
        abort[d] = 1'b0;
        stall[d] = 1'b0;
    endtask

    // Expected behaviour: the sequence is the list of round indices from
    // 12-rounds up to 11 in steps of the unroll factor, one entry per
    // non-stalled cycle, followed by a single done cycle.
    task automatic run_body(input int d, input int m, input int stall_at, input int stall_len,
                            input bit rnd_stall, input int abort_at, input bit b2b, input int m2);
        int u;
        int nrounds;
        int q[$];
        int idx;
        int held;
        int nstall;
        int cyc;
        bit stall_now;
        u       = (d == 1) ? 2 : 1;
        nrounds = (m != 0) ? 8 : 12;
        for (int r = 12 - nrounds; r < 12; r += u) q.push_back(r);
        idx    = 0;
        held   = 0;
        nstall = 0;
        cyc    = 0;
        @(negedge clk);
        start[d] = 1'b0;
        mode[d]  = 1'($urandom_range(0, 1));
        while (idx < q.size()) begin
            if (cyc > 200) begin
                chk("run_timeout", 32'(cyc), 32'd0);
                return;
            end
            chk("run_busy",  32'(busy[d]),  32'd1);
            chk("run_ready", 32'(ready[d]), 32'd0);
            chk("run_round", 32'(round[d]), 32'(q[idx]));
            chk("run_last",  32'(last[d]),  32'(idx == q.size() - 1));
            chk("run_done",  32'(done[d]),  32'd0);
`ifdef ASCON_ROUND_CONST_EN
            begin
                logic [15:0] exp_rc;
                exp_rc = '0;
                for (int k = 0; k < u; k++) begin
                    int r;
                    r = (q[idx] + k) % 16;
                    exp_rc[8*k +: 8] = 8'(((15 - r) << 4) + r);
                end
                chk("run_rc", 32'(rc[d]), 32'(exp_rc));
            end
`endif
            stall_now = 1'b0;
            if (q[idx] == stall_at && held < stall_len) begin
                stall_now = 1'b1;
                held++;
            end else if (rnd_stall && $urandom_range(0, 3) == 0) begin
                stall_now = 1'b1;
            end
            stall[d] = stall_now;
            mode[d]  = 1'($urandom_range(0, 1));
            start[d] = 1'($urandom_range(0, 1));
            if (q[idx] == abort_at) begin
                abort[d] = 1'b1;
                @(negedge clk);
                abort[d] = 1'b0;
                start[d] = 1'b0;
                stall[d] = 1'b0;
                chk_idle(d, "abort");
                chk("abort_done", 32'(done[d]), 32'd0);
                @(negedge clk);
                chk("abort_nodone_later", 32'(done[d]), 32'd0);
                return;
            end
            if (stall_now) nstall++;
            else idx++;
            @(negedge clk);
            cyc++;
        end
        chk("run_len", 32'(cyc), 32'(nrounds / u + nstall));
        chk("done_pulse", 32'(done[d]), 32'd1);
        chk_idle(d, "done");
        if (b2b) begin
            start[d] = 1'b1;
            mode[d]  = m2[0];
            abort[d] = 1'b0;
            stall[d] = 1'b0;
        end else begin
            start[d] = 1'b0;
            stall[d] = 1'($urandom_range(0, 1));
            @(negedge clk);
            stall[d] = 1'b0;
            chk("done_one_cycle", 32'(done[d]), 32'd0);
            chk_idle(d, "after_done");
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            mode[i]  = 1'b0;
            stall[i] = 1'b0;
            abort[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk_idle(i, "reset");
            chk("reset_done", 32'(done[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Full mode A, UNROLL=1
        kick(0, 0);
        run_body(0, 0, -1, 0, 1'b0, -1, 1'b0, 0);

        // Mode B, UNROLL=2
        kick(1, 1);
        run_body(1, 1, -1, 0, 1'b0, -1, 1'b0, 0);

        // Three-cycle stall at round 5
        kick(0, 0);
        run_body(0, 0, 5, 3, 1'b0, -1, 1'b0, 0);

        // Abort at round 7, then start+abort together while idle
        kick(0, 0);
        run_body(0, 0, -1, 0, 1'b0, 7, 1'b0, 0);
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        abort[0] = 1'b0;
        chk_idle(0, "start_abort_idle");
        @(negedge clk);
        chk_idle(0, "start_abort_idle2");

        // Asynchronous reset in the middle of a run
        kick(0, 0);
        repeat (4) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        chk("pre_reset_round", 32'(round[0]), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk_idle(0, "async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        kick(0, 0);
        run_body(0, 0, -1, 0, 1'b0, -1, 1'b0, 0);

        // Back-to-back: start in the DONE cycle
        kick(1, 0);
        run_body(1, 0, -1, 0, 1'b0, -1, 1'b1, 1);
        run_body(1, 1, -1, 0, 1'b0, -1, 1'b0, 0);

`ifdef ASCON_ROUND_CONST_EN
        kick(1, 0);
        @(negedge clk);
        start[1] = 1'b0;
        chk("rc_round0", 32'(rc[1]), 32'h0000_E1F0);
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        kick(1, 1);
        @(negedge clk);
        start[1] = 1'b0;
        chk("rc_round4", 32'(rc[1]), 32'h0000_A5B4);
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
`endif

        // Randomized sequences with random stalls, aborts and chaining
        begin
            bit pending;
            int pm;
            int pd;
            pending = 1'b0;
            pm      = 0;
            pd      = 0;
            repeat (24) begin
                int d;
                int m;
                int u;
                int nr;
                int ab;
                bit chain;
                if (pending) begin
                    d = pd;
                    m = pm;
                end else begin
                    d = int'($urandom_range(0, 1));
                    m = int'($urandom_range(0, 1));
                    kick(d, m);
                end
                u  = (d == 1) ? 2 : 1;
                nr = (m != 0) ? 8 : 12;
                ab = -1;
                if ($urandom_range(0, 3) == 0)
                    ab = (12 - nr) + u * int'($urandom_range(0, nr / u - 1));
                chain   = (ab < 0) && ($urandom_range(0, 2) == 0);
                pm      = int'($urandom_range(0, 1));
                pd      = d;
                run_body(d, m, -1, 0, 1'b1, ab, chain, pm);
                pending = chain;
            end
            if (pending) begin
                run_body(pd, pm, -1, 0, 1'b0, -1, 1'b0, 0);
            end
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire
